// File: rtl/axil_mem_responder.sv
// AXI4-Lite word memory responder with independent AW/W capture, a fixed-latency
// read path and saturating transaction/error counters.
module axil_mem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [15:0]           wr_count,
  output logic [15:0]           rd_count,
  output logic [15:0]           err_count
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFF_W;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam logic [IDX_W:0] DEPTH_L  = (IDX_W + 1)'(DEPTH);
  localparam logic [3:0]     LAT_INIT = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);
  localparam logic [1:0]     OKAY     = 2'b00;
  localparam logic [1:0]     SLVERR   = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} rd_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              aw_held, w_held;
  logic [IDX_W-1:0]  aw_idx;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              commit, wr_in_range;

  rd_state_t         state, next_state;
  logic [3:0]        lat_cnt;
  logic [IDX_W-1:0]  ar_idx, rd_idx_sel;
  logic              ar_hs, r_hs, load_resp, rd_in_range;

  logic [1:0]        err_inc;
  logic [16:0]       err_sum;
  logic [2*OFF_W-1:0] unused_addr_bits;

  assign unused_addr_bits = {awaddr[OFF_W-1:0], araddr[OFF_W-1:0]};

  // Write side: one AW slot and one W slot, joined when both are full.
  assign awready     = !aw_held;
  assign wready      = !w_held;
  assign commit      = aw_held && w_held && (!bvalid || bready);
  assign wr_in_range = {1'b0, aw_idx} < DEPTH_L;

  always_ff @(posedge clock) begin
    if (reset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (awvalid && awready) begin
          aw_held <= 1'b1;
          aw_idx  <= awaddr[ADDR_W-1:OFF_W];
        end
        if (wvalid && wready) begin
          w_held <= 1'b1;
          w_data <= wdata;
          w_strb <= wstrb;
        end
      end
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= wr_in_range ? OKAY : SLVERR;
      end else if (bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Memory is never reset; a commit coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (!reset && commit && wr_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb[b]) mem[aw_idx[MEM_AW-1:0]][b*8 +: 8] <= w_data[b*8 +: 8];
      end
    end
  end

  // Read FSM: state register, next-state logic, outputs.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (ar_hs) next_state = (RD_LAT == 0) ? RESP : WAIT;
      WAIT:    if (lat_cnt == 4'd0) next_state = RESP;
      RESP:    if (rready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    arready = (state == IDLE);
    rvalid  = (state == RESP);
  end

  // Memory is sampled on entry to RESP, so a same-cycle write yields old data.
  assign load_resp   = (state != RESP) && (next_state == RESP);
  assign rd_idx_sel  = (state == IDLE) ? araddr[ADDR_W-1:OFF_W] : ar_idx;
  assign rd_in_range = {1'b0, rd_idx_sel} < DEPTH_L;

  always_ff @(posedge clock) begin
    if (reset) begin
      lat_cnt <= 4'd0;
      rdata   <= '0;
      rresp   <= OKAY;
    end else begin
      if (ar_hs) begin
        ar_idx  <= araddr[ADDR_W-1:OFF_W];
        lat_cnt <= LAT_INIT;
      end else if (state == WAIT && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (load_resp) begin
        rdata <= rd_in_range ? mem[rd_idx_sel[MEM_AW-1:0]] : '0;
        rresp <= rd_in_range ? OKAY : SLVERR;
      end
    end
  end

  // Error responses from both channels may land in the same cycle.
  assign err_inc = 2'(commit && !wr_in_range) + 2'(load_resp && !rd_in_range);
  assign err_sum = {1'b0, err_count} + 17'(err_inc);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_count  <= 16'd0;
      rd_count  <= 16'd0;
      err_count <= 16'd0;
    end else begin
      if (commit && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (r_hs && rd_count != 16'hFFFF)   rd_count <= rd_count + 16'd1;
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule

// File: doc/axil_mem_responder.md
AXIL_MEM_RESPONDER -- requirements
Module: axil_mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 16, byte address width.
REQ-003 SHALL have parameter DEPTH, default 256, memory depth in words; must be a power of 2.
REQ-004 SHALL have parameter RD_LAT, default 3, extra read wait cycles; legal range 0..15.
REQ-005 SHALL have the following ports, one per line (name, direction, width, meaning):
- clock  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- awaddr  in  ADDR_W  write address
- awvalid  in  1
- awready  out  1
- wdata  in  DATA_W
- wstrb  in  DATA_W/8  byte enables
- wvalid  in  1
- wready  out  1
- bresp  out  2
- bvalid  out  1
- bready  in  1
- araddr  in  ADDR_W  read address
- arvalid  in  1
- arready  out  1
- rdata  out  DATA_W
- rresp  out  2
- rvalid  out  1
- rready  in  1
- wr_count  out  16  committed writes, saturating
- rd_count  out  16  completed reads, saturating
- err_count  out  16  SLVERR responses, saturating

Function
REQ-006 SHALL follow AXI4-Lite handshake rules: a transfer occurs in a cycle where valid and ready are both 1; once raised, bvalid/rvalid and their payloads SHALL stay stable until the handshake.
REQ-007 SHALL compute the word index as addr[ADDR_W-1:log2(DATA_W/8)] and ignore the low byte-offset bits; index >= DEPTH is out of range.
REQ-008 SHALL hold one AW entry and one W entry, each captured independently; awready = !aw_held and wready = !w_held.
REQ-009 SHALL commit a write in the cycle where aw_held && w_held && (!bvalid || bready):
- clear both held flags;
- set bvalid on the next cycle;
- back-to-back B responses are allowed.
REQ-010 On an in-range commit, SHALL update only the bytes enabled by wstrb and return bresp=OKAY (2'b00).
REQ-011 On an out-of-range commit, SHALL leave memory unchanged and return bresp=SLVERR (2'b10).
REQ-012 SHALL implement the read FSM with states IDLE, WAIT and RESP; arready=1 only in IDLE.
REQ-013 In IDLE, an AR handshake SHALL capture the address and move to WAIT with counter=RD_LAT, or directly to RESP when RD_LAT=0.
REQ-014 In WAIT, SHALL decrement the counter each cycle and move to RESP after it reaches 0; rvalid SHALL rise exactly RD_LAT+1 cycles after the AR handshake cycle.
REQ-015 In RESP, SHALL hold rvalid=1 until the rready handshake, then return to IDLE; the next AR is accepted no earlier than the cycle after the R handshake.
REQ-016 An out-of-range read SHALL return rdata=0 with rresp=SLVERR; an in-range read returns the memory word with rresp=OKAY.
REQ-017 A write commit and a read to the same word in the same cycle SHALL return the old data (read sampled before write).
REQ-018 SHALL update the counters as follows, each saturating at 16'hFFFF:
- wr_count +1 per write commit;
- rd_count +1 per R handshake;
- err_count +1 per SLVERR response issued.
REQ-019 When a write SLVERR and a read SLVERR are issued in the same cycle, err_count SHALL increment by 2, or saturate if fewer than 2 counts remain.

Reset
REQ-020 While reset=1 at a rising edge, SHALL clear the following on the next edge:
- awready=1, wready=1, arready=1;
- bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0;
- held flags cleared, read FSM=IDLE;
- all counters=0.
REQ-021 Memory contents SHALL NOT be reset.
REQ-022 A reset asserted mid-transaction (held entries, WAIT or RESP) SHALL abandon the transaction with no memory update and no response.

Verification (DATA_W=32, DEPTH=256, RD_LAT=3)
REQ-023 AW 0x0010 + W 0xDEADBEEF, strb 4'hF in the same cycle -> bvalid next cycle with OKAY, wr_count=1; then AR 0x0010 -> rvalid 4 cycles later with rdata 0xDEADBEEF, OKAY, rd_count=1.
REQ-024 W presented 3 cycles before AW -> wready=0 from the cycle after W acceptance; commit and bvalid follow the cycle after AW acceptance.
REQ-025 Write 0x00001234 with strb 4'h3 to 0x0010 -> subsequent read returns 0xDEAD1234.
REQ-026 Write and read to 0x0400 (word 256) -> both SLVERR, read rdata=0, err_count=2, memory unchanged.
REQ-027 bready held low 5 cycles with a second AW/W pair pending -> bvalid stays 1, second pair held (awready=wready=0), and it commits in the cycle bready=1.
REQ-028 reset asserted during WAIT -> next cycle rvalid=0, arready=1, all counters=0; no R beat ever appears for the abandoned read.
